// File: rtl/perf_pkg.sv
// perf_pkg: register map offsets and control/command bit indices for the perf counter bank
package perf_pkg;
  localparam logic [7:0] CTRL_OFF = 8'h00;
  localparam logic [7:0] MASK_OFF = 8'h04;
  localparam logic [7:0] CMD_OFF  = 8'h08;
  localparam logic [7:0] OVF_OFF  = 8'h0C;
  localparam logic [7:0] CNT_BASE = 8'h10;
  localparam int CTRL_GEN  = 0;
  localparam int CTRL_SAT  = 1;
  localparam int CMD_CLEAR = 0;
  localparam int CMD_SNAP  = 1;
endpackage

// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: MMIO read/write bus between the CPU decoder and the counter bank
interface perf_counter_bank_if;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rd_valid;
  modport master(output wr_en, rd_en, addr, wdata, input rdata, rd_valid);
  modport slave(input wr_en, rd_en, addr, wdata, output rdata, rd_valid);
endinterface

// File: rtl/perf_counter_slice.sv
// perf_counter_slice: one live event counter with clear/preload/increment priority and wrap or saturate
module perf_counter_slice #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         sat,
  output logic [W-1:0] value,
  output logic         ovf_pulse
);
  assign ovf_pulse = inc & ~clear & ~load & (&value);
  always_ff @(posedge clk)
    if (rst || clear) value <= '0;
    else if (load) value <= load_val;
    else if (inc) value <= (&value) ? (sat ? value : '0) : value + 1'b1;
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: MMIO bank of event counters with enables, overflow flags and atomic snapshot
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] event_i,
  perf_counter_bank_if.slave bus
);
  logic [1:0]           ctrl;
  logic [NUM_CNT-1:0]   mask, ovf, inc, load, ovf_pulse, w1c;
  logic [CNT_WIDTH-1:0] live [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow [NUM_CNT];
  logic [7:0]           a;
  logic                 clear, snap, rd_valid;
  logic [31:0]          rmux, rdata;
  assign a     = {bus.addr[7:2], 2'b00};
  assign clear = bus.wr_en && a == CMD_OFF && bus.wdata[CMD_CLEAR];
  assign snap  = bus.wr_en && a == CMD_OFF && bus.wdata[CMD_SNAP];
  assign w1c   = (bus.wr_en && a == OVF_OFF) ? bus.wdata[NUM_CNT-1:0] : '0;
  assign bus.rdata    = rdata;
  assign bus.rd_valid = rd_valid;
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
    assign inc[i]  = ctrl[CTRL_GEN] & mask[i] & event_i[i];
    assign load[i] = bus.wr_en && a == 8'(CNT_BASE + 4 * i);
    perf_counter_slice #(.W(CNT_WIDTH)) u_slice (
      .clk(clk),
      .rst(rst),
      .inc(inc[i]),
      .clear(clear),
      .load(load[i]),
      .load_val(bus.wdata[CNT_WIDTH-1:0]),
      .sat(ctrl[CTRL_SAT]),
      .value(live[i]),
      .ovf_pulse(ovf_pulse[i])
    );
  end
  always_comb begin
    rmux = a == CTRL_OFF ? 32'(ctrl) : a == MASK_OFF ? 32'(mask) : a == OVF_OFF ? 32'(ovf) : 32'h0;
    for (int i = 0; i < NUM_CNT; i++)
      if (a == 8'(CNT_BASE + 4 * i)) rmux = 32'(shadow[i]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      ctrl <= 2'b01;
      mask <= '1;
      ovf  <= '0;
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
    end else begin
      if (bus.wr_en && a == CTRL_OFF) ctrl <= bus.wdata[1:0];
      if (bus.wr_en && a == MASK_OFF) mask <= bus.wdata[NUM_CNT-1:0];
      ovf <= clear ? '0 : (ovf & ~w1c) | ovf_pulse;
      for (int i = 0; i < NUM_CNT; i++) if (snap) shadow[i] <= live[i];
    end
  always_ff @(posedge clk)
    if (rst) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.rd_en;
      if (bus.rd_en) rdata <= rmux;
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: scoreboard bench driving a 32-bit and an 8-bit bank with identical stimulus
module tb_perf_counter_bank;
  import perf_pkg::*;
  typedef struct {
    string       tag;
    bit          sel;
    logic [31:0] exp;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ev = '0;
  int         n_vec = 0;
  int         n_err = 0;
  exp_t       q[$];
  perf_counter_bank_if b0();
  perf_counter_bank_if b1();
  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .event_i(ev), .bus(b0));
  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .event_i(ev), .bus(b1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_set(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
    b0.wr_en = w; b0.rd_en = r; b0.addr = a; b0.wdata = d;
    b1.wr_en = w; b1.rd_en = r; b1.addr = a; b1.wdata = d;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_set(1'b1, 1'b0, a, d);
    cyc();
    bus_set(1'b0, 1'b0, 8'h00, 32'h0);
  endtask
  task automatic rd(input logic [7:0] a, input bit sel, input logic [31:0] exp, input string tag);
    q.push_back('{tag: tag, sel: sel, exp: exp});
    bus_set(1'b0, 1'b1, a, 32'h0);
    cyc();
    bus_set(1'b0, 1'b0, 8'h00, 32'h0);
  endtask
  task automatic run(input logic [3:0] e, input int n);
    ev = e;
    repeat (n) cyc();
    ev = '0;
  endtask
  always @(negedge clk)
    if (b0.rd_valid) begin
      if (q.size() == 0) check("spurious_rd_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check(e.tag, e.sel ? b1.rdata : b0.rdata, e.exp);
      end
    end
  initial begin
    bus_set(1'b0, 1'b0, 8'h00, 32'h0);
    repeat (2) cyc();
    check("rst_rd_valid", 32'(b0.rd_valid), 32'd0);
    check("rst_rdata", b0.rdata, 32'h0);
    rst = 1'b0;
    rd(CTRL_OFF, 0, 32'h1, "rst_ctrl");
    rd(MASK_OFF, 0, 32'hF, "rst_mask");
    rd(OVF_OFF, 0, 32'h0, "rst_ovf");
    rd(CNT_BASE, 0, 32'h0, "rst_shadow0");
    run(4'b0001, 100);
    wr(CMD_OFF, 32'h2);
    rd(CNT_BASE, 0, 32'd100, "cnt0_100");
    rd(CNT_BASE + 8'h04, 0, 32'd0, "cnt1_idle");
    wr(MASK_OFF, 32'h2);
    run(4'hF, 10);
    wr(CMD_OFF, 32'h2);
    rd(CNT_BASE, 0, 32'd100, "mask_cnt0_held");
    rd(CNT_BASE + 8'h04, 0, 32'd10, "mask_cnt1_10");
    rd(CNT_BASE + 8'h08, 0, 32'd0, "mask_cnt2_held");
    rd(CNT_BASE + 8'h0C, 0, 32'd0, "mask_cnt3_held");
    wr(CTRL_OFF, 32'h0);
    run(4'hF, 10);
    wr(CMD_OFF, 32'h2);
    rd(CNT_BASE + 8'h04, 0, 32'd10, "gen_off_cnt1");
    wr(CTRL_OFF, 32'h1);
    wr(MASK_OFF, 32'hF);
    wr(CMD_OFF, 32'h1);
    wr(CNT_BASE, 32'hFE);
    run(4'b0001, 3);
    wr(CMD_OFF, 32'h2);
    rd(CNT_BASE, 1, 32'h01, "wrap8_val");
    rd(OVF_OFF, 1, 32'h1, "wrap8_ovf");
    rd(CNT_BASE, 0, 32'h101, "wrap32_val");
    rd(OVF_OFF, 0, 32'h0, "wrap32_ovf");
    wr(CTRL_OFF, 32'h3);
    wr(CMD_OFF, 32'h1);
    rd(OVF_OFF, 1, 32'h0, "clear_ovf");
    wr(CNT_BASE, 32'hFE);
    run(4'b0001, 3);
    wr(CMD_OFF, 32'h2);
    rd(CNT_BASE, 1, 32'hFF, "sat8_val");
    rd(OVF_OFF, 1, 32'h1, "sat8_ovf");
    rd(CNT_BASE, 0, 32'h101, "sat32_val");
    wr(OVF_OFF, 32'h1);
    rd(OVF_OFF, 1, 32'h0, "ovf_w1c");
    ev = 4'b0001;
    wr(OVF_OFF, 32'h1);
    ev = '0;
    rd(OVF_OFF, 1, 32'h1, "ovf_w1c_vs_set");
    rd(CTRL_OFF, 0, 32'h3, "ctrl_sat");
    wr(CTRL_OFF, 32'h1);
    wr(CMD_OFF, 32'h1);
    run(4'b0001, 50);
    wr(CMD_OFF, 32'h3);
    rd(CNT_BASE, 0, 32'd50, "snapclr_shadow32");
    rd(CNT_BASE, 1, 32'd50, "snapclr_shadow8");
    rd(OVF_OFF, 1, 32'h0, "snapclr_ovf");
    wr(CMD_OFF, 32'h2);
    rd(CNT_BASE, 0, 32'd0, "snapclr_live0");
    ev = 4'b0100;
    wr(CNT_BASE + 8'h08, 32'h1234);
    ev = '0;
    wr(CMD_OFF, 32'h2);
    rd(CNT_BASE + 8'h08, 0, 32'h1234, "preload32_drop_inc");
    rd(CNT_BASE + 8'h08, 1, 32'h34, "preload8_drop_inc");
    rd(CMD_OFF, 0, 32'h0, "cmd_reads_0");
    rd(CNT_BASE + 8'h10, 0, 32'h0, "chan4_unmapped");
    rd(8'h80, 0, 32'h0, "unmapped_80");
    q.push_back('{tag: "rd_wr_same", sel: 0, exp: 32'hF});
    bus_set(1'b1, 1'b1, MASK_OFF, 32'h5);
    cyc();
    bus_set(1'b0, 1'b0, 8'h00, 32'h0);
    rd(MASK_OFF, 0, 32'h5, "mask_after_wr");
    wr(MASK_OFF, 32'hF);
    ev = 4'hF;
    run(4'hF, 5);
    ev = 4'hF;
    rst = 1'b1;
    bus_set(1'b0, 1'b1, CNT_BASE, 32'h0);
    cyc();
    check("midrst_rd_valid", 32'(b0.rd_valid), 32'd0);
    check("midrst_rdata", b0.rdata, 32'h0);
    rst = 1'b0;
    ev = '0;
    bus_set(1'b0, 1'b0, 8'h00, 32'h0);
    wr(CMD_OFF, 32'h2);
    rd(CNT_BASE, 0, 32'h0, "postrst_cnt0");
    rd(CNT_BASE + 8'h04, 0, 32'h0, "postrst_cnt1");
    rd(CNT_BASE + 8'h08, 1, 32'h0, "postrst_cnt2_8");
    rd(CTRL_OFF, 0, 32'h1, "postrst_ctrl");
    rd(OVF_OFF, 1, 32'h0, "postrst_ovf");
    repeat (4) cyc();
    if (q.size() != 0) check("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of hardware performance counters for the RISC-V CPU, generalising the fixed cycle/instruction counter pair into NUM_CNT independent event counters. Each channel counts a one-bit event strobe (channel 0 is tied to 1 for cycles; channel 1 to instruction-retire). The bank adds per-channel enable, wrap or saturate mode, sticky overflow flags, and an atomic snapshot so that software and benches read a coherent set. It sits on the CPU's memory-mapped I/O path behind the existing address decoder.

## Interface
- NUM_CNT, 4, number of counter channels (1..16)
- CNT_WIDTH, 32, counter width in bits (1..32)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- event_i  in  NUM_CNT  per-channel increment strobe; one increment per cycle when high
- wr_en  in  1  MMIO write strobe
- rd_en  in  1  MMIO read strobe
- addr  in  8  byte offset within the bank (word aligned; addr[1:0] ignored)
- wdata  in  32  write data
- rdata  out  32  read data, registered
- rd_valid  out  1  high exactly one cycle after an accepted rd_en

## Operation
- Register map (byte offsets):
  - 0x00 CTRL rw: bit0 GEN (global enable), bit1 SAT (1 = saturate, 0 = wrap); other bits read 0.
  - 0x04 MASK rw: bits[NUM_CNT-1:0] per-channel enable.
  - 0x08 CMD wo, reads 0: bit0 CLEAR (zero all live counters and OVF), bit1 SNAP (copy all live counters to shadow).
  - 0x0C OVF: read sticky flags [NUM_CNT-1:0]; write-1-to-clear.
  - 0x10 + 4*i: read returns shadow[i] zero-extended to 32 bits; write preloads live[i] with wdata[CNT_WIDTH-1:0].
  - Unmapped offsets and channels i ≥ NUM_CNT: read 0, writes ignored.
- Counting: live[i] increments when GEN & MASK[i] & event_i[i].
- At all-ones with an increment: wrap mode → 0, OVF[i] set; saturate mode → holds all-ones, OVF[i] set.
- Priority per channel, per cycle: CLEAR > preload write > increment. A dropped increment is lost, not deferred.
- Same-cycle interactions:
  - SNAP and CLEAR written together: shadow captures pre-clear values.
  - SNAP alongside an increment: shadow captures the pre-increment value.
  - OVF write-1-to-clear in the same cycle as a new overflow: flag stays set.
- Reads always come from shadow registers. Software must issue SNAP before reading counters. Live values are never directly readable.

## Timing
- Reset values:
  - CTRL = 0x1 (counting, wrap).
  - MASK = all ones.
  - live = 0, shadow = 0, OVF = 0.
  - rdata = 0, rd_valid = 0.
- A write takes effect at the clock edge where wr_en is sampled. Counting under the new CTRL/MASK begins the following cycle.
- Read latency is 1 cycle. rdata and rd_valid update on the edge after rd_en. rdata holds its value until the next read.
- rd_en and wr_en to the same address in one cycle: the read returns the pre-write value.
- Reset asserted mid-operation: all state returns to reset values on that edge, and any in-flight read is dropped (rd_valid = 0).
- Throughput: one increment per channel per cycle, plus one MMIO access per cycle.

## Structure
- Package perf_pkg holds:
  - register offset localparams (CTRL, MASK, CMD, OVF, CNT_BASE);
  - CTRL bit indices (GEN, SAT);
  - CMD bit indices (CLEAR, SNAP).
- Sub-module perf_counter_slice, one per channel via generate:
  - inputs: inc, clear, load, load_val, sat;
  - outputs: value, ovf_pulse.
- The top level holds CTRL, MASK, OVF, shadow registers, address decode and the read mux.

## Test plan
- Reset, then 100 cycles with event_i = 4'b0001, then SNAP, then read 0x10 → rdata = 100 one cycle after rd_en; read 0x14 → 0.
- Load MASK = 4'b0010 with events on all channels for 10 cycles → only channel 1 advances by 10. GEN = 0 stops all channels.
- Wrap and saturate (CNT_WIDTH = 8):
  - Wrap: preload 0xFE, apply 3 events, SNAP → 0x01, OVF = 0x1.
  - Saturate: same stimulus → 0xFF, OVF = 0x1.
  - Write 1 to OVF → reads 0.
- Write CMD = 0x3 while counter 0 holds 50 → shadow0 = 50 and live0 = 0. A following SNAP with no events → 0.
- Preload write to counter 2 with 0x1234 in the same cycle as event_i[2] → live2 = 0x1234 (increment dropped).
- Assert rst mid-count with rd_en high → next cycle rd_valid = 0, then all reads return 0 and CTRL reads 0x1.
